// File: rtl/irq_controller.sv
// Priority interrupt controller: edge-latches eight lines, masks and nests them by
// priority, and hands one vector at a time to the core over an intr/intl toggle pair.
module irq_controller #(
  parameter logic [15:0] PORT_BASE   = 16'h0020,
  parameter logic [7:0]  VECTOR_BASE = 8'h08
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  lines,
  input  logic [15:0] port,
  input  logic [7:0]  port_o,
  input  logic        port_w,
  output logic [7:0]  port_rd,
  output logic [7:0]  irq,
  output logic        intr,
  input  logic        intl,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  sync1_q, sync2_q, prev_q;
  logic [7:0]  irr_q, irr_d;
  logic [7:0]  isr_q, isr_d;
  logic [7:0]  imr_q, imr_d;
  logic [7:0]  base_q, base_d;
  logic [7:0]  irq_q, irq_d;
  logic        intr_q, intr_d;
  logic [2:0]  sel_q, sel_d;

  logic [7:0]  line_edge;
  logic [7:0]  pend;
  logic [2:0]  cand;
  logic        cand_valid;
  logic [7:0]  le_mask;
  logic        eligible;
  logic        dispatch;
  logic        ack;
  logic        wr_eoi, wr_imr, wr_base;
  logic [7:0]  eoi_clr;

  assign line_edge = sync2_q & ~prev_q;
  assign pend      = irr_q & ~imr_q;

  always_comb begin
    cand_valid = 1'b0;
    cand       = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (pend[i]) begin
        cand_valid = 1'b1;
        cand       = 3'(i);
      end
    end
  end

  // Fully nested: any in-service level at or above the candidate blocks it.
  assign le_mask  = 8'hFF >> (3'd7 - cand);
  assign eligible = cand_valid && ((isr_q & le_mask) == 8'h00);
  assign dispatch = (state_q == ST_IDLE) && eligible;
  assign ack      = (state_q == ST_WAIT) && (intl == intr_q);

  assign wr_eoi  = port_w && (port == PORT_BASE) && (port_o == 8'h20);
  assign wr_imr  = port_w && (port == PORT_BASE + 16'd1);
  assign wr_base = port_w && (port == PORT_BASE + 16'd2);
  assign eoi_clr = isr_q & (~isr_q + 8'd1);

  // State and register file
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_INIT;
      sync1_q <= 8'h00;
      sync2_q <= 8'h00;
      prev_q  <= 8'h00;
      irr_q   <= 8'h00;
      isr_q   <= 8'h00;
      imr_q   <= 8'hFF;
      base_q  <= VECTOR_BASE & 8'hF8;
      irq_q   <= 8'h00;
      intr_q  <= 1'b0;
      sel_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      sync1_q <= lines;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      irr_q   <= irr_d;
      isr_q   <= isr_d;
      imr_q   <= imr_d;
      base_q  <= base_d;
      irq_q   <= irq_d;
      intr_q  <= intr_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: state_d = ST_IDLE;
      ST_IDLE: if (dispatch) state_d = ST_WAIT;
      ST_WAIT: if (ack) state_d = ST_IDLE;
      default: state_d = ST_INIT;
    endcase
  end

  // Handshake outputs and register updates; EOI clears before the ack sets ISR[sel].
  always_comb begin
    irq_d  = irq_q;
    intr_d = intr_q;
    sel_d  = sel_q;
    irr_d  = irr_q;
    isr_d  = isr_q;
    imr_d  = imr_q;
    base_d = base_q;
    case (state_q)
      ST_INIT: intr_d = intl;
      ST_IDLE: begin
        if (dispatch) begin
          irq_d  = base_q | {5'b00000, cand};
          sel_d  = cand;
          intr_d = ~intr_q;
        end
      end
      default: ;
    endcase
    if (wr_eoi) isr_d = isr_q & ~eoi_clr;
    if (ack) begin
      isr_d[sel_q] = 1'b1;
      irr_d[sel_q] = 1'b0;
    end
    irr_d = irr_d | line_edge;
    if (wr_imr)  imr_d  = port_o;
    if (wr_base) base_d = port_o & 8'hF8;
  end

  always_comb begin
    port_rd = 8'h00;
    if (port == PORT_BASE)              port_rd = isr_q;
    else if (port == PORT_BASE + 16'd1) port_rd = imr_q;
    else if (port == PORT_BASE + 16'd2) port_rd = irr_q;
  end

  assign irq       = irq_q;
  assign intr      = intr_q;
  assign state_dbg = state_q;

endmodule
